// File: rtl/message_composer_if.sv
// Byte stream from the message composer to a downstream consumer (UART/LCD writer).
// The master offers tx_data/tx_last under tx_valid; the slave accepts with tx_ready.
// A byte moves on every cycle where tx_valid and tx_ready are both high.
interface message_composer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/message_composer.sv
// Line buffer for keypad characters with space/backspace edits; streams the message on send.
// Latency: edits land one edge after the event; first byte is offered the cycle after the send edge.
// Backpressure: tx_data/tx_last hold while tx_ready is low; 1 byte/cycle when tx_ready stays high.
// Optional: define COMPOSER_TERMINATOR_EN to append a 0x0D terminator byte to every message.
module message_composer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  input  logic             btn_space,
  input  logic             btn_back,
  input  logic             btn_send,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic [LEN_W-1:0] buf_len,
  output logic             busy,
  output logic             rejected,
  message_composer_if.master tx
);

  localparam int               IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [7:0]       SPACE_CH = 8'h20;
  localparam logic [7:0]       TERM_CH  = 8'h0D;
`ifdef COMPOSER_TERMINATOR_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  typedef enum logic {EDIT, SEND} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [MAX_LEN];
  logic             send_q, back_q, space_q;
  logic             send_rise, back_rise, space_rise;
  logic [LEN_W-1:0] tx_idx, tx_idx_nxt;
  logic             full, empty, handshake;
  logic             wr_en, len_dec, tx_start, tx_adv, tx_done, rej_nxt;
  logic [7:0]       wr_dat;

  assign send_rise  = btn_send  & ~send_q;
  assign back_rise  = btn_back  & ~back_q;
  assign space_rise = btn_space & ~space_q;
  assign full       = (buf_len == FULL_LEN);
  assign empty      = (buf_len == '0);
  assign handshake  = tx.tx_valid & tx.tx_ready;
  assign tx_idx_nxt = tx_idx + ONE;
  assign busy       = (state == SEND);
  // The message is offered for the whole of SEND, so valid is simply the state.
  assign tx.tx_valid = busy;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EDIT;
    else        state <= state_nxt;
  end

  // Event arbitration: next state plus one-cycle strobes for the datapath.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_dat    = char_in;
    len_dec   = 1'b0;
    tx_start  = 1'b0;
    tx_adv    = 1'b0;
    tx_done   = 1'b0;
    rej_nxt   = 1'b0;
    case (state)
      EDIT: begin
        if (send_rise && !empty) begin
          // A character confirmed in the send cycle still makes it into the message.
          state_nxt = SEND;
          tx_start  = 1'b1;
          if (char_valid) begin
            if (!full) wr_en   = 1'b1;
            else       rej_nxt = 1'b1;
          end
          if (back_rise || space_rise) rej_nxt = 1'b1;
        end else if (char_valid) begin
          if (!full) wr_en   = 1'b1;
          else       rej_nxt = 1'b1;
          if (back_rise || space_rise) rej_nxt = 1'b1;
        end else if (back_rise) begin
          len_dec = !empty;
          if (space_rise) rej_nxt = 1'b1;
        end else if (space_rise) begin
          wr_dat = SPACE_CH;
          if (!full) wr_en   = 1'b1;
          else       rej_nxt = 1'b1;
        end
      end
      SEND: begin
        rej_nxt = char_valid | send_rise | back_rise | space_rise;
        if (handshake) begin
          if (tx.tx_last) begin
            tx_done   = 1'b1;
            state_nxt = EDIT;
          end else begin
            tx_adv = 1'b1;
          end
        end
      end
      default: state_nxt = EDIT;
    endcase
  end

  // Character storage; contents survive reset, buf_len alone marks what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[buf_len[IDX_W-1:0]] <= wr_dat;
  end

  // Edge detectors, length, transmit pointer/outputs, read port and reject pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      send_q     <= 1'b0;
      back_q     <= 1'b0;
      space_q    <= 1'b0;
      buf_len    <= '0;
      tx_idx     <= '0;
      tx.tx_data <= 8'h00;
      tx.tx_last <= 1'b0;
      rd_data    <= 8'h00;
      rejected   <= 1'b0;
    end else begin
      send_q   <= btn_send;
      back_q   <= btn_back;
      space_q  <= btn_space;
      rejected <= rej_nxt;

      if (tx_done)      buf_len <= '0;
      else if (wr_en)   buf_len <= buf_len + ONE;
      else if (len_dec) buf_len <= buf_len - ONE;

      if (tx_start) begin
        // buf_len >= 1 here, so mem[0] already holds the first character.
        tx_idx     <= '0;
        tx.tx_data <= mem[0];
        tx.tx_last <= !TERM_EN && (buf_len == ONE) && !wr_en;
      end else if (tx_adv) begin
        tx_idx <= tx_idx_nxt;
        if (TERM_EN && (tx_idx_nxt == buf_len)) begin
          tx.tx_data <= TERM_CH;
          tx.tx_last <= 1'b1;
        end else begin
          tx.tx_data <= mem[tx_idx_nxt[IDX_W-1:0]];
          tx.tx_last <= !TERM_EN && (tx_idx_nxt == buf_len - ONE);
        end
      end else if (tx_done) begin
        tx_idx     <= '0;
        tx.tx_data <= 8'h00;
        tx.tx_last <= 1'b0;
      end

      rd_data <= (rd_addr < buf_len) ? mem[rd_addr[IDX_W-1:0]] : 8'h00;
    end
  end

endmodule

// File: tb/tb_message_composer.sv
// Self-checking bench for message_composer: directed spec scenarios plus randomized edits
// and random backpressure, compared against a queue-based model of the line buffer.
module tb_message_composer;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
`ifdef COMPOSER_TERMINATOR_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       char_in;
  logic             char_valid, btn_space, btn_back, btn_send;
  logic [LEN_W-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic [LEN_W-1:0] buf_len;
  logic             busy, rejected;

  message_composer_if tx_if();

  message_composer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .btn_space(btn_space), .btn_back(btn_back), .btn_send(btn_send),
    .rd_addr(rd_addr), .rd_data(rd_data), .buf_len(buf_len),
    .busy(busy), .rejected(rejected), .tx(tx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];   // model: the characters currently in the line

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One edit event (char and/or button edges in the same cycle), then a quiet cycle.
  task automatic step(input bit cv, input logic [7:0] c, input bit sp, input bit bk);
    bit rej;
    rej = 1'b0;
    if (cv) begin
      if (q.size() < MAX_LEN) q.push_back(c); else rej = 1'b1;
      if (sp || bk) rej = 1'b1;
    end else if (bk) begin
      if (q.size() > 0) void'(q.pop_back());
      if (sp) rej = 1'b1;
    end else if (sp) begin
      if (q.size() < MAX_LEN) q.push_back(8'h20); else rej = 1'b1;
    end
    char_in = c; char_valid = cv; btn_space = sp; btn_back = bk;
    tick();
    char_valid = 1'b0; btn_space = 1'b0; btn_back = 1'b0;
    chk("edit_rejected", 32'(rejected), 32'(rej));
    chk("edit_len", 32'(buf_len), 32'(q.size()));
    tick();
    chk("quiet_rejected", 32'(rejected), 32'd0);
  endtask

  task automatic rd_chk(input int a);
    logic [7:0] e;
    rd_addr = LEN_W'(a);
    e = (a < q.size()) ? q[a] : 8'h00;
    tick();
    chk("rd_data", 32'(rd_data), 32'(e));
  endtask

  // Send the model's line; mode 0: ready always, 1: ready 1,0,0,1 then 1, 2: random.
  task automatic send_msg(input bit with_c, input logic [7:0] c, input int mode, input int inject);
    logic [7:0] exp[$];
    int idx, n;
    bit r;
    if (with_c) q.push_back(c);
    exp = q;
    if (TERM) exp.push_back(8'h0D);
    n = exp.size();
    tx_if.tx_ready = 1'b0;
    char_in = c; char_valid = with_c; btn_send = 1'b1;
    tick();
    char_valid = 1'b0; btn_send = 1'b0;
    chk("send_busy", 32'(busy), 32'd1);
    chk("send_start_rejected", 32'(rejected), 32'd0);
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < n; cyc++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = !(cyc == 1 || cyc == 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_if.tx_ready = r;
      chk("tx_valid", 32'(tx_if.tx_valid), 32'd1);
      chk("tx_data", 32'(tx_if.tx_data), 32'(exp[idx]));
      chk("tx_last", 32'(tx_if.tx_last), 32'(idx == n - 1));
      if (cyc == inject) begin
        char_valid = 1'b1;
        char_in = 8'($urandom_range(33, 126));
      end
      tick();
      if (cyc == inject) begin
        char_valid = 1'b0;
        chk("send_inject_rejected", 32'(rejected), 32'd1);
      end
      if (r) idx++;
    end
    tx_if.tx_ready = 1'b0;
    chk("send_complete", 32'(idx), 32'(n));
    chk("end_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_len", 32'(buf_len), 32'd0);
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; char_in = 8'h00; char_valid = 1'b0;
    btn_space = 1'b0; btn_back = 1'b0; btn_send = 1'b0;
    rd_addr = '0; tx_if.tx_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    chk("rst_tx_last", 32'(tx_if.tx_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rejected", 32'(rejected), 32'd0);
    chk("rst_len", 32'(buf_len), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Edits: H, I, space, back -> "HI".
    step(1'b1, 8'h48, 1'b0, 1'b0);
    step(1'b1, 8'h49, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("hi_len", 32'(buf_len), 32'd2);
    rd_addr = LEN_W'(1);
    tick();
    chk("hi_rd1", 32'(rd_data), 32'h49);
    rd_chk(0);
    rd_chk(2);
    step(1'b1, 8'h21, 1'b1, 1'b0);   // coincident space is dropped
    send_msg(1'b0, 8'h00, 0, -1);

    // Backspace on an empty line: no-op, no pulse.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Empty send ignored.
    btn_send = 1'b1; tick(); btn_send = 1'b0;
    chk("empty_send_busy", 32'(busy), 32'd0);
    chk("empty_send_rejected", 32'(rejected), 32'd0);
    tick();

    // "AB" with constant ready, then with ready 1,0,0,1.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    send_msg(1'b0, 8'h00, 0, -1);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    send_msg(1'b0, 8'h00, 1, -1);

    // 'C' coincident with the send edge; a char during SEND is rejected.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    send_msg(1'b1, 8'h43, 0, 1);

    // Fill past capacity: only the 17th is rejected.
    for (int i = 0; i < MAX_LEN + 1; i++) step(1'b1, 8'($urandom_range(33, 126)), 1'b0, 1'b0);
    chk("full_len", 32'(buf_len), 32'd16);
    step(1'b0, 8'h00, 1'b1, 1'b0);   // space while full
    for (int i = 0; i < 6; i++) rd_chk($urandom_range(0, 20));
    send_msg(1'b0, 8'h00, 2, $urandom_range(0, 10));

    // Randomized edit sessions with random backpressure.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 4))
          0, 1: step(1'b1, 8'($urandom_range(33, 126)), 1'b0, 1'b0);
          2:    step(1'b0, 8'h00, 1'b1, 1'b0);
          3:    step(1'b0, 8'h00, 1'b0, 1'b1);
          default: step(1'b1, 8'($urandom_range(33, 126)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        endcase
      end
      for (int a = 0; a <= MAX_LEN; a++) rd_chk(a);
      if (q.size() == 0) step(1'b1, 8'h5A, 1'b0, 1'b0);
      send_msg(1'b0, 8'h00, 2, $urandom_range(0, 8));
    end

    // Reset during the second byte of a message.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    btn_send = 1'b1; tick(); btn_send = 1'b0;
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    chk("mid_tx_data", 32'(tx_if.tx_data), 32'h42);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_len", 32'(buf_len), 32'd0);
    chk("mid_rst_data", 32'(tx_if.tx_data), 32'd0);
    rst_n = 1'b1;
    q.delete();
    tick();
    btn_send = 1'b1; tick(); btn_send = 1'b0;
    chk("post_rst_send_busy", 32'(busy), 32'd0);
    chk("post_rst_send_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("post_rst_send_rejected", 32'(rejected), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/message_composer.md
# message_composer

Collects confirmed characters from the phone-style keypad decoder into a line buffer, applies space and backspace edits, and on a send request streams the finished message to a downstream byte consumer (UART/LCD writer) over a valid/ready handshake. It sits directly after the keypad decoder and sequences its output into complete messages. A read port gives the display logic access to the buffer while the user is editing.

## Interface
- MAX_LEN, 16, buffer capacity in characters (2..255).
- LEN_W, $clog2(MAX_LEN+1), width of length/address fields (5 at default).

- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- char_in  in  8  ASCII from decoder, sampled when char_valid=1.
- char_valid  in  1  one-cycle pulse: character confirmed.
- btn_space  in  1  synchronized level; its rising edge appends 0x20.
- btn_back  in  1  synchronized level; its rising edge deletes the last character.
- btn_send  in  1  synchronized level; its rising edge starts transmission.
- rd_addr  in  LEN_W  display read address.
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency; 0x00 if rd_addr >= buf_len.
- buf_len  out  LEN_W  current character count.
- tx_data  out  8  byte being offered downstream.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts when tx_valid and tx_ready are both 1.
- tx_last  out  1  qualifies the final byte of a message.
- busy  out  1  high in SEND.
- rejected  out  1  one-cycle pulse: an input event was discarded.

## Operation
- Rising edges on btn_* are detected internally (previous-value registers cleared by reset). char_valid is already a pulse and is used directly.
- States: EDIT (reset state) and SEND.
- EDIT, per cycle, evaluated in this priority order:
  - send_rise with buf_len>0:
    - If char_valid is also high and the buffer is not full, append char_in first.
    - Enter SEND. Coincident back/space edges are dropped and rejected pulses.
  - send_rise with buf_len=0: ignored, no pulse.
  - char_valid:
    - If not full: write buffer[buf_len], buf_len+1.
    - If full: discard and pulse rejected.
    - A coincident back/space edge is dropped and rejected pulses.
  - back_rise: if buf_len>0, buf_len−1; at 0 it is a no-op with no pulse.
  - space_rise: append 0x20 under the same full rule as char_valid.
- SEND:
  - Transmit buffer[0..buf_len−1] in order. Index counter tx_idx starts at 0.
  - tx_last=1 on the final byte.
  - Any char_valid or button edge arriving in SEND is discarded and pulses rejected.
  - After the final handshake: buf_len←0, tx_idx←0, return to EDIT.
- Buffer contents are not cleared on reset or after send; only buf_len governs validity.

## Timing
- Reset values: tx_data=0x00, tx_valid=0, tx_last=0, busy=0, rejected=0, buf_len=0, rd_data=0x00, state=EDIT.
- Edits: buf_len updates on the edge after the triggering cycle.
- Send start: the send edge is detected in cycle N. busy=1 and tx_valid=1 with tx_data=buffer[0] from cycle N+1.
- Handshake (AXI-stream rules):
  - tx_data, tx_valid and tx_last hold stable until the transfer.
  - After each transfer the next byte is presented the following cycle, so back-to-back throughput is 1 byte/cycle while tx_ready=1.
  - tx_valid never drops mid-message.
- After the last transfer at cycle M: tx_valid=0, busy=0, buf_len=0 at M+1. EDIT accepts input from M+1.
- rd_data: rd_addr sampled at cycle K appears at K+1. The port remains readable during SEND.
- rst_n low mid-SEND: all outputs take reset values at the next edge and the message is abandoned.

## Configuration
- COMPOSER_TERMINATOR_EN defined:
  - After the final buffer byte, one extra byte 0x0D is sent. tx_last asserts on 0x0D only.
  - Message length on the wire is buf_len+1.
  - An empty-buffer send is still ignored.
- Not defined: no terminator; tx_last asserts on buffer[buf_len−1].

## Test plan
- Reset, then char pulses 'H'(0x48), 'I'(0x49), space edge, then back edge -> buf_len=2; rd_addr=1 gives rd_data=0x49 next cycle.
- 17 char_valid pulses with MAX_LEN=16 -> buf_len=16, rejected pulses exactly once, on the 17th.
- Buffer "AB", send edge, tx_ready=1 -> tx_valid from N+1; 0x41 then 0x42 with tx_last on 0x42 (0x0D with tx_last when COMPOSER_TERMINATOR_EN); then buf_len=0, busy=0.
- Buffer "AB", send, tx_ready toggling 1,0,0,1 -> tx_data and tx_last stay stable while tx_ready=0; no byte duplicated or lost.
- char_valid 'C' in the same cycle as a send edge on "AB" -> transmits 0x41, 0x42, 0x43; a char_valid during SEND pulses rejected and buf_len is 0 afterward.
- rst_n low during the second byte of SEND -> next cycle tx_valid=0, busy=0, buf_len=0; a following send edge is ignored.
